regfile_wb_arbiter: RTL

- Shares the register file's single write port between two write-back requesters: port s0 (ALU result) and port s1 (load/store unit).
- Each requester has a DEPTH-entry queue with a valid/ready handshake.
- An arbiter pops at most one queue head per cycle into a registered write stage that drives we3/wa3/wd3.
- Exports a per-register pending mask that the issue stage uses for RAW stall detection.

---
 rtl/regfile_wb_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-port write-back arbiter in front of the register file's single write port.
// Define WB_RR_ARB_EN for round-robin arbitration; otherwise s1 has fixed priority.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s0_valid,
    output logic                 s0_ready,
    input  logic [AW-1:0]        s0_addr,
    input  logic [DW-1:0]        s0_data,
    input  logic                 s1_valid,
    output logic                 s1_ready,
    input  logic [AW-1:0]        s1_addr,
    input  logic [DW-1:0]        s1_data,
    output logic                 we3,
    output logic [AW-1:0]        wa3,
    output logic [DW-1:0]        wd3,
    output logic [(2**AW)-1:0]   pending
);

    localparam int unsigned IW   = $clog2(DEPTH);
    localparam int unsigned PW   = IW + 1;
    localparam int unsigned NREG = 2**AW;

    logic [PW-1:0] r_wptr  [2];
    logic [PW-1:0] r_rptr  [2];
    logic [AW-1:0] r_qaddr [2][DEPTH];
    logic [DW-1:0] r_qdata [2][DEPTH];

    logic          r_we;
    logic [AW-1:0] r_wa;
    logic [DW-1:0] r_wd;

    logic [1:0]    w_in_valid;
    logic [AW-1:0] w_in_addr [2];
    logic [DW-1:0] w_in_data [2];

    logic [1:0]    w_empty;
    logic [1:0]    w_full;
    logic [1:0]    w_ready;
    logic [1:0]    w_push;
    logic [1:0]    w_grant;
    logic [PW-1:0] w_cnt [2];
    logic          w_slot_vld [2][DEPTH];

    logic          w_pref;
    logic          w_any_grant;
    logic          w_sel;
    logic [AW-1:0] w_head_addr;
    logic [DW-1:0] w_head_data;
    logic [NREG-1:0] w_pend;

    assign w_in_valid   = {s1_valid, s0_valid};
    assign w_in_addr[0] = s0_addr;
    assign w_in_addr[1] = s1_addr;
    assign w_in_data[0] = s0_data;
    assign w_in_data[1] = s1_data;

    // Queue status; ready is purely state based so a full queue never accepts.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_empty[p] = (r_wptr[p] == r_rptr[p]);
            w_full[p]  = (r_wptr[p][PW-1] != r_rptr[p][PW-1]) &&
                         (r_wptr[p][IW-1:0] == r_rptr[p][IW-1:0]);
            w_ready[p] = !w_full[p] && !rst;
            w_push[p]  = w_in_valid[p] && w_ready[p];
            w_cnt[p]   = r_wptr[p] - r_rptr[p];
        end
    end

`ifdef WB_RR_ARB_EN
    logic r_rr_next;

    // Port preferred on the next contended cycle: the one not granted last.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_next <= 1'b0;
        end else if (w_any_grant) begin
            r_rr_next <= ~w_sel;
        end
    end

    assign w_pref = r_rr_next;
`else
    assign w_pref = 1'b1;
`endif

    always_comb begin
        w_grant = 2'b00;
        if (!w_empty[0] && !w_empty[1]) begin
            w_grant[w_pref] = 1'b1;
        end else if (!w_empty[0]) begin
            w_grant[0] = 1'b1;
        end else if (!w_empty[1]) begin
            w_grant[1] = 1'b1;
        end
    end

    assign w_any_grant = |w_grant;
    assign w_sel       = w_grant[1];
    assign w_head_addr = r_qaddr[w_sel][r_rptr[w_sel][IW-1:0]];
    assign w_head_data = r_qdata[w_sel][r_rptr[w_sel][IW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                r_wptr[p] <= '0;
                r_rptr[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_push[p]) begin
                    r_wptr[p] <= r_wptr[p] + PW'(1);
                end
                if (w_grant[p]) begin
                    r_rptr[p] <= r_rptr[p] + PW'(1);
                end
            end
        end
    end

    // Queue storage carries no reset; only slots between the pointers are live.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (w_push[p]) begin
                r_qaddr[p][r_wptr[p][IW-1:0]] <= w_in_addr[p];
                r_qdata[p][r_wptr[p][IW-1:0]] <= w_in_data[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we <= 1'b0;
            r_wa <= '0;
            r_wd <= '0;
        end else if (w_any_grant) begin
            r_we <= (w_head_addr != '0);
            r_wa <= w_head_addr;
            r_wd <= w_head_data;
        end else begin
            r_we <= 1'b0;
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_slot_vld[p][i] = ({1'b0, IW'(IW'(i) - r_rptr[p][IW-1:0])} < w_cnt[p]);
            end
        end
    end

    // Register 0 is never pending since it is never written.
    always_comb begin
        w_pend = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_slot_vld[p][i]) begin
                    w_pend[r_qaddr[p][i]] = 1'b1;
                end
            end
        end
        if (r_we) begin
            w_pend[r_wa] = 1'b1;
        end
        w_pend[0] = 1'b0;
        if (rst) begin
            w_pend = '0;
        end
    end

    assign s0_ready = w_ready[0];
    assign s1_ready = w_ready[1];
    assign we3      = r_we;
    assign wa3      = r_wa;
    assign wd3      = r_wd;
    assign pending  = w_pend;

endmodule
